// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers one row of exp values, accumulates the row sum,
// then emits each value divided by the sum as an unsigned Q1.FRAC_W probability.
module softmax_norm #(
  parameter int DATA_W  = 16,
  parameter int ROW_LEN = 8,
  parameter int FRAC_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_exp,
  input  logic              i_last,
  output logic              i_ready,
  output logic              o_valid,
  output logic [FRAC_W:0]   o_prob,
  output logic              o_last,
  input  logic              o_ready
);

  localparam int CNT_W  = $clog2(ROW_LEN);
  localparam int LEN_W  = CNT_W + 1;
  localparam int SUM_W  = DATA_W + CNT_W;
  localparam int DCNT_W = $clog2(FRAC_W + 2);

  typedef enum logic [1:0] {ACCUM, DIV, OUT} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [CNT_W-1:0]    k_reg;
  logic [SUM_W-1:0]    sum_reg;
  logic [DCNT_W-1:0]   div_cnt_reg;
  logic [SUM_W-1:0]    rem_reg;
  logic [FRAC_W:0]     q_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic [DATA_W-1:0]   buf_mem [ROW_LEN];

  logic                accept;
  logic                row_close;
  logic                out_is_last;
  logic [SUM_W:0]      trial;
  logic                q_bit;

  assign accept      = (state_reg == ACCUM) && i_valid;
  assign row_close   = accept && (i_last || (cnt_reg == CNT_W'(ROW_LEN - 1)));
  assign out_is_last = ({1'b0, k_reg} == (len_reg - LEN_W'(1)));

  assign i_ready = rstn && (state_reg == ACCUM);
  assign o_valid = rstn && (state_reg == OUT);
  assign o_last  = o_valid && out_is_last;
  assign o_prob  = o_valid ? q_reg : '0;

  // First iteration brings down the whole buffered value: the dividend is
  // buf << FRAC_W and the quotient only has FRAC_W+1 bits, so the top part
  // (buf >> 1) plus the next dividend bit (buf[0]) is exactly buf.
  always_comb begin
    trial = (div_cnt_reg == DCNT_W'(1)) ? (SUM_W + 1)'(rd_data_reg) : {rem_reg, 1'b0};
    q_bit = (sum_reg != '0) && (trial >= {1'b0, sum_reg});
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM: if (row_close) state_next = DIV;
      DIV:   if (div_cnt_reg == DCNT_W'(FRAC_W + 1)) state_next = OUT;
      OUT:   if (o_ready) state_next = out_is_last ? ACCUM : DIV;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= ACCUM;
    else       state_reg <= state_next;
  end

  // Row buffer: plain array with registered read so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (accept) buf_mem[cnt_reg] <= i_exp;
    rd_data_reg <= buf_mem[k_reg];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_reg     <= '0;
      len_reg     <= '0;
      k_reg       <= '0;
      sum_reg     <= '0;
      div_cnt_reg <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            sum_reg <= sum_reg + SUM_W'(i_exp);
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
          if (row_close) begin
            len_reg     <= {1'b0, cnt_reg} + LEN_W'(1);
            k_reg       <= '0;
            div_cnt_reg <= '0;
          end
        end
        DIV: begin
          div_cnt_reg <= div_cnt_reg + DCNT_W'(1);
          // Cycle 0 waits for the registered buffer read.
          if (div_cnt_reg == '0) begin
            rem_reg <= '0;
            q_reg   <= '0;
          end else begin
            rem_reg <= q_bit ? SUM_W'(trial - {1'b0, sum_reg}) : SUM_W'(trial);
            q_reg   <= {q_reg[FRAC_W-1:0], q_bit};
          end
        end
        OUT: begin
          if (o_ready) begin
            if (out_is_last) begin
              cnt_reg <= '0;
              sum_reg <= '0;
            end else begin
              k_reg       <= k_reg + CNT_W'(1);
              div_cnt_reg <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: each task drives one scenario and checks
// probabilities, o_last placement, latency and handshake behaviour inline.
module tb_softmax_norm;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic [15:0] i_exp;
  logic        i_last;
  logic        i_ready;
  logic        o_valid;
  logic [8:0]  o_prob;
  logic        o_last;
  logic        o_ready;

  int checks = 0;
  int errors = 0;

  softmax_norm #(.DATA_W(16), .ROW_LEN(8), .FRAC_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid(i_valid), .i_exp(i_exp), .i_last(i_last), .i_ready(i_ready),
    .o_valid(o_valid), .o_prob(o_prob), .o_last(o_last), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [15:0] v, input logic l);
    int n = 0;
    i_valid = 1'b1;
    i_exp   = v;
    i_last  = l;
    while (i_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic take();
    o_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready got=%0b want=0", i_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%0b want=0", o_valid); end
    checks++; if (o_prob !== 9'd0) begin errors++; $display("FAIL reset_o_prob got=%0d want=0", o_prob); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last got=%0b want=0", o_last); end
    rstn = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_release_i_ready got=%0b want=1", i_ready); end
    $display("reset done");
  endtask

  task automatic test_basic();
    int vals[4] = '{10, 20, 30, 40};
    int expp[4] = '{25, 51, 76, 102};
    int cyc;
    for (int i = 0; i < 4; i++) send(16'(vals[i]), 1'(i == 3));
    for (int i = 0; i < 4; i++) begin
      wait_out(cyc);
      checks++; if (cyc !== 10) begin errors++; $display("FAIL basic_latency[%0d] got=%0d want=10", i, cyc); end
      checks++; if (o_prob !== 9'(expp[i])) begin errors++; $display("FAIL basic_prob[%0d] got=%0d want=%0d", i, o_prob, expp[i]); end
      checks++; if (o_last !== 1'(i == 3)) begin errors++; $display("FAIL basic_last[%0d] got=%0b want=%0b", i, o_last, i == 3); end
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL basic_i_ready_busy[%0d] got=%0b want=0", i, i_ready); end
      $display("basic out %0d prob=%0d last=%0b latency=%0d", i, o_prob, o_last, cyc);
      take();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop[%0d] got=%0b want=0", i, o_valid); end
    end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL basic_i_ready_return got=%0b want=1", i_ready); end
  endtask

  task automatic test_single();
    int cyc;
    send(16'd5, 1'b1);
    wait_out(cyc);
    checks++; if (o_prob !== 9'd256) begin errors++; $display("FAIL single_prob got=%0d want=256", o_prob); end
    checks++; if (o_last !== 1'b1) begin errors++; $display("FAIL single_last got=%0b want=1", o_last); end
    $display("single out prob=%0d last=%0b", o_prob, o_last);
    take();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL single_i_ready got=%0b want=1", i_ready); end
  endtask

  task automatic test_zero_row();
    int cyc;
    for (int i = 0; i < 3; i++) send(16'd0, 1'(i == 2));
    for (int i = 0; i < 3; i++) begin
      wait_out(cyc);
      checks++; if (cyc >= 200) begin errors++; $display("FAIL zero_timeout[%0d] got=%0d want<200", i, cyc); end
      checks++; if (o_prob !== 9'd0) begin errors++; $display("FAIL zero_prob[%0d] got=%0d want=0", i, o_prob); end
      checks++; if (o_last !== 1'(i == 2)) begin errors++; $display("FAIL zero_last[%0d] got=%0b want=%0b", i, o_last, i == 2); end
      $display("zero out %0d prob=%0d last=%0b", i, o_prob, o_last);
      take();
    end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL zero_i_ready got=%0b want=1", i_ready); end
  endtask

  task automatic test_forced_close();
    logic [15:0] vals[2] = '{16'h0100, 16'hFFFF};
    int cyc;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) send(vals[r], 1'b0);
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL forced_closed[%0d] got=%0b want=0", r, i_ready); end
      for (int i = 0; i < 8; i++) begin
        wait_out(cyc);
        checks++; if (o_prob !== 9'd32) begin errors++; $display("FAIL forced_prob[%0d][%0d] got=%0d want=32", r, i, o_prob); end
        checks++; if (o_last !== 1'(i == 7)) begin errors++; $display("FAIL forced_last[%0d][%0d] got=%0b want=%0b", r, i, o_last, i == 7); end
        $display("forced row %0d out %0d prob=%0d last=%0b", r, i, o_prob, o_last);
        take();
      end
      checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL forced_i_ready[%0d] got=%0b want=1", r, i_ready); end
    end
  endtask

  task automatic test_backpressure();
    int vals[4] = '{10, 20, 30, 40};
    int expp[4] = '{25, 51, 76, 102};
    int cyc;
    for (int i = 0; i < 4; i++) send(16'(vals[i]), 1'(i == 3));
    for (int i = 0; i < 4; i++) begin
      wait_out(cyc);
      checks++; if (o_prob !== 9'(expp[i])) begin errors++; $display("FAIL bp_prob[%0d] got=%0d want=%0d", i, o_prob, expp[i]); end
      checks++; if (o_last !== 1'(i == 3)) begin errors++; $display("FAIL bp_last[%0d] got=%0b want=%0b", i, o_last, i == 3); end
      $display("bp out %0d prob=%0d last=%0b", i, o_prob, o_last);
      if (i == 1) begin
        o_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got=%0b want=1", s, o_valid); end
          checks++; if (o_prob !== 9'd51) begin errors++; $display("FAIL bp_hold_prob[%0d] got=%0d want=51", s, o_prob); end
          checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_i_ready[%0d] got=%0b want=0", s, i_ready); end
        end
      end
      take();
    end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_i_ready_return got=%0b want=1", i_ready); end
  endtask

  task automatic test_reset_mid();
    int vals[4] = '{10, 20, 30, 40};
    int expp[2] = '{64, 192};
    int cyc;
    int stale = 0;
    for (int i = 0; i < 4; i++) send(16'(vals[i]), 1'(i == 3));
    wait_out(cyc);
    take();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_o_valid got=%0b want=0", o_valid); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_i_ready got=%0b want=0", i_ready); end
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_release_i_ready got=%0b want=1", i_ready); end
    for (int s = 0; s < 20; s++) begin
      if (o_valid === 1'b1) stale++;
      @(posedge clk); #1;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_rst_stale got=%0d want=0", stale); end
    $display("mid reset done stale=%0d", stale);
    send(16'd1, 1'b0);
    send(16'd3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_out(cyc);
      checks++; if (o_prob !== 9'(expp[i])) begin errors++; $display("FAIL mid_rst_prob[%0d] got=%0d want=%0d", i, o_prob, expp[i]); end
      checks++; if (o_last !== 1'(i == 1)) begin errors++; $display("FAIL mid_rst_last[%0d] got=%0b want=%0b", i, o_last, i == 1); end
      $display("post-reset out %0d prob=%0d last=%0b", i, o_prob, o_last);
      take();
    end
  endtask

  initial begin
    clk     = 1'b0;
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_exp   = '0;
    i_last  = 1'b0;
    o_ready = 1'b1;
    test_reset();
    test_basic();
    test_single();
    test_zero_row();
    test_forced_close();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
